// File: rtl/imem_program_loader.sv
// Serial-byte program loader: frames a length-prefixed, XOR-checksummed image
// into 32-bit instruction memory writes while holding the CPU stalled.
//
// state  | meaning
// IDLE   | waiting for start, bytes ignored
// LEN_HI | expecting word count bits [15:8]
// LEN_LO | expecting word count bits [7:0], then range check
// DATA   | assembling big-endian words, one write per fourth byte
// CHECK  | expecting checksum byte
// ERROR  | failed load, cpu_hold kept high until restarted
module imem_program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q;
  logic [ADDR_W:0]   word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [7:0]        acc_q;
  logic [23:0]       asm_q;

  logic [15:0]       len_full;
  logic [16:0]       words_written;
  logic              do_start, do_hi, do_lo, do_ovf, do_byte, do_write;
  logic              chk_ok, chk_bad, busy_d;

  assign len_full      = {len_q[15:8], rx_data};
  // word_idx is one bit wider than the address so a full-depth image ends cleanly
  assign words_written = 17'(word_idx_q) + 17'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_start = 1'b0;
    do_hi    = 1'b0;
    do_lo    = 1'b0;
    do_ovf   = 1'b0;
    do_byte  = 1'b0;
    do_write = 1'b0;
    chk_ok   = 1'b0;
    chk_bad  = 1'b0;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          do_start = 1'b1;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          do_hi   = 1'b1;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          do_lo = 1'b1;
          if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else if ({1'b0, len_full} > MAX_WORDS) begin
            do_ovf  = 1'b1;
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          do_byte = 1'b1;
          if (byte_idx_q == 2'd3) begin
            do_write = 1'b1;
            if (words_written == {1'b0, len_q}) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data == acc_q) begin
            chk_ok  = 1'b1;
            state_d = S_IDLE;
          end else begin
            chk_bad = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE) && (state_d != S_ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      acc_q      <= '0;
      asm_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      busy    <= busy_d;
      imem_we <= do_write;
      if (do_start) begin
        cpu_hold   <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        acc_q      <= '0;
        word_idx_q <= '0;
        byte_idx_q <= '0;
      end
      if (do_hi) len_q[15:8] <= rx_data;
      if (do_lo) len_q[7:0]  <= rx_data;
      if (do_ovf) error <= 1'b1;
      if (do_byte) begin
        asm_q      <= {asm_q[15:0], rx_data};
        acc_q      <= acc_q ^ rx_data;
        byte_idx_q <= byte_idx_q + 2'd1;
      end
      if (do_write) begin
        imem_addr  <= word_idx_q[ADDR_W-1:0];
        imem_wdata <= {asm_q, rx_data};
        word_idx_q <= word_idx_q + 1'b1;
      end
      if (chk_ok) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (chk_bad) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized scoreboard bench for imem_program_loader: a frame-level model
// predicts writes and final status; a monitor pops expected writes on imem_we.
module tb_imem_program_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold, busy, done, error;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  imem_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the next predicted write.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        wr_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                   imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (imem_addr !== e.a || imem_wdata !== e.d) begin
            errors++;
            $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                     imem_addr, imem_wdata, e.a, e.d);
          end
        end
      end
    end
  end

  // Frame-level reference: parse the byte list, queue expected writes, predict outcome.
  function automatic void model(input bq_t f, output bit ok, output bit bad);
    int         n;
    logic [7:0] x;
    ok  = 1'b0;
    bad = 1'b0;
    n   = int'({f[0], f[1]});
    if (n > DEPTH) begin
      bad = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.a = 8'(i);
      w.d = {f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]};
      x   = x ^ f[2+4*i] ^ f[3+4*i] ^ f[4+4*i] ^ f[5+4*i];
      exp_q.push_back(w);
    end
    if (f[2+4*n] == x) ok = 1'b1;
    else               bad = 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
    idle(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = st;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
  endtask

  task automatic run_frame(input string name, input bq_t f, input int max_gap, input int start_at);
    bit ok, bad;
    pulse_start();
    model(f, ok, bad);
    for (int i = 0; i < f.size(); i++)
      send_byte(f[i], (max_gap > 0) ? int'($urandom_range(max_gap)) : 0, (i == start_at));
    check({name, "_done"}, 32'(done), 32'(ok));
    check({name, "_error"}, 32'(error), 32'(bad));
    check({name, "_hold"}, 32'(cpu_hold), 32'(!ok));
    check({name, "_busy"}, 32'(busy), 32'd0);
    idle(2);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_we"}, 32'(imem_we), 32'd0);
    check({name, "_addr"}, 32'(imem_addr), 32'd0);
    check({name, "_wdata"}, imem_wdata, 32'd0);
    check({name, "_hold"}, 32'(cpu_hold), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    bq_t good, badf, f;
    good = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h51};
    idle(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    run_frame("two_word", good, 0, -1);

    badf = good;
    badf[10] = 8'h52;
    run_frame("bad_chk", badf, 0, -1);
    run_frame("retry_good", good, 0, -1);

    run_frame("zero_len", '{8'h00, 8'h00, 8'h00}, 0, -1);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * i), 0, 1'b0);
    idle(2);
    check("idle_bytes_done_kept", 32'(done), 32'd1);

    // Oversize length must fail right after LEN_LO, before any payload.
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    check("oversize_error", 32'(error), 32'd1);
    check("oversize_hold", 32'(cpu_hold), 32'd1);
    check("oversize_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0, 1'b0);
    idle(2);

    f = '{8'h01, 8'h00};
    begin
      logic [7:0] x = 8'h00;
      for (int i = 0; i < 4 * DEPTH; i++) begin
        logic [7:0] b = 8'($urandom);
        f.push_back(b);
        x = x ^ b;
      end
      f.push_back(x);
    end
    run_frame("full_depth", f, 0, -1);

    // Reset in the middle of the first word: nothing written, later bytes ignored.
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h24, 0, 1'b0);
    send_byte(8'h08, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0, 1'b0);
    idle(2);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_done", 32'(done), 32'd0);

    run_frame("gapped", good, 5, 4);

    for (int k = 0; k < 20; k++) begin
      int         n = int'($urandom_range(8, 1));
      logic [7:0] x = 8'h00;
      f = '{8'h00, 8'(n)};
      for (int i = 0; i < 4 * n; i++) begin
        logic [7:0] b = 8'($urandom);
        f.push_back(b);
        x = x ^ b;
      end
      if ($urandom_range(9) == 0) x = x ^ 8'(1 << $urandom_range(7));
      f.push_back(x);
      run_frame($sformatf("rand%0d", k), f, int'($urandom_range(5)),
                ($urandom_range(1) == 1) ? int'($urandom_range(4 * n + 1, 3)) : -1);
    end

    idle(3);
    check("final_pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
